// File: rtl/updown_chk_pkg.sv
// Shared definitions for the up/down triangle-sequence checker.
//   - state_t       : checker state machine encoding (IDLE, ACQUIRE, LOCKED)
//   - UPDN_WIDTH_DEF: default count width
//   - UPDN_LOCK_DEF : default number of consistent steps needed to lock
//   - ERRCNT_W      : width of the optional saturating error counter
package updown_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int UPDN_WIDTH_DEF = 3;
    localparam int UPDN_LOCK_DEF  = 2;
    localparam int ERRCNT_W       = 8;

endpackage

// File: rtl/updown_predict.sv
// Next-value predictor for the triangle sequence 0..MAX..0.
// Given the last accepted sample and its direction, produces the value the
// stream must show next and the direction that step implies. Endpoints force
// a turnaround regardless of the incoming direction.
// Ports:
//   i_prev     : last accepted sample
//   i_dir      : direction of the last accepted step (1 = up)
//   o_expect   : expected next sample
//   o_next_dir : direction of the expected step
module updown_predict #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_prev,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_expect,
    output logic             o_next_dir
);

    localparam logic [WIDTH-1:0] MAX  = '1;
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    always_comb begin
        o_expect   = i_prev;
        o_next_dir = i_dir;
        if (i_prev == MAX) begin
            o_expect   = MAX - ONE;
            o_next_dir = 1'b0;
        end else if (i_prev == ZERO) begin
            o_expect   = ONE;
            o_next_dir = 1'b1;
        end else if (i_dir) begin
            o_expect   = i_prev + ONE;
        end else begin
            o_expect   = i_prev - ONE;
        end
    end

endmodule

// File: rtl/updown_seq_checker.sv
// Receive-side monitor for a WIDTH-bit up/down (triangle) counter stream.
// Locks onto 0,1,..,MAX,MAX-1,..,0,.. and reports direction, period
// completion and sequence breaks. All outputs are registered.
// Optional feature macro: UPDN_CHK_ERRCNT_EN adds a saturating error counter.
// Ports:
//   i_clk           : clock, rising edge
//   i_rst           : asynchronous active-high reset
//   i_cnt           : observed count, sampled every edge
//   o_locked        : sequence is being tracked
//   o_dir           : direction of last accepted step (1 = up)
//   o_err           : one-cycle pulse on a failed locked prediction
//   o_period_done   : one-cycle pulse when a locked sample returns to 0
//   o_err_cnt       : saturating count of err pulses (UPDN_CHK_ERRCNT_EN only)
//
// state    | meaning
// IDLE     | first edge after reset: capture the sample, no checking
// ACQUIRE  | counting consistent steps until LOCK_CNT is reached
// LOCKED   | every sample must match the prediction
module updown_seq_checker
    import updown_chk_pkg::*;
#(
    parameter int WIDTH    = UPDN_WIDTH_DEF,
    parameter int LOCK_CNT = UPDN_LOCK_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [WIDTH-1:0]    i_cnt,
    output logic                o_locked,
    output logic                o_dir,
    output logic                o_err,
    output logic                o_period_done
`ifdef UPDN_CHK_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0] o_err_cnt
`endif
);

    localparam logic [WIDTH-1:0] MAX      = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [2:0]       LOCK_THR = 3'(LOCK_CNT);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [2:0]       r_match;
    logic             r_locked;
    logic             r_dir;
    logic             r_err;
    logic             r_period_done;

    logic [WIDTH-1:0] w_expect;
    logic             w_next_dir;
    logic             w_hit;
    logic             w_up_step;
    logic             w_down_step;
    logic             w_valid;
    logic [2:0]       w_match_inc;
    logic             w_miss;

    updown_predict #(.WIDTH(WIDTH)) u_predict (
        .i_prev     (r_prev),
        .i_dir      (r_dir),
        .o_expect   (w_expect),
        .o_next_dir (w_next_dir)
    );

    // A step that equals the prediction is exactly a consistent step:
    // continuing in dir, or the forced turnaround at 0 / MAX.
    assign w_hit       = (i_cnt == w_expect);
    // Endpoint guards exclude the modular wraps 7->0 and 0->7.
    assign w_up_step   = (r_prev != MAX)  && (i_cnt == r_prev + ONE);
    assign w_down_step = (r_prev != ZERO) && (i_cnt == r_prev - ONE);
    assign w_valid     = w_up_step || w_down_step;
    assign w_match_inc = r_match + 3'd1;
    assign w_miss      = (r_state == ST_LOCKED) && !w_hit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_prev        <= '0;
            r_match       <= '0;
            r_locked      <= 1'b0;
            r_dir         <= 1'b1;
            r_err         <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_err         <= 1'b0;
            r_period_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_prev  <= i_cnt;
                    r_state <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    r_prev <= i_cnt;
                    if (w_hit) begin
                        r_match <= w_match_inc;
                        r_dir   <= w_next_dir;
                        if (w_match_inc >= LOCK_THR) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else if (w_valid) begin
                        // Valid step against the current direction restarts
                        // the run at one step in the new direction.
                        r_match <= 3'd1;
                        r_dir   <= w_up_step;
                        if (LOCK_THR <= 3'd1) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                        end
                    end else begin
                        r_match <= '0;
                    end
                end
                ST_LOCKED: begin
                    r_prev <= i_cnt;
                    if (w_hit) begin
                        r_dir         <= w_next_dir;
                        r_period_done <= (i_cnt == ZERO);
                    end else begin
                        r_err    <= 1'b1;
                        r_locked <= 1'b0;
                        r_match  <= '0;
                        r_state  <= ST_ACQUIRE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign o_locked      = r_locked;
    assign o_dir         = r_dir;
    assign o_err         = r_err;
    assign o_period_done = r_period_done;

`ifdef UPDN_CHK_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    // Counts on the same edge that raises err, so both are visible together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_cnt <= '0;
        end else if (w_miss && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_updown_seq_checker.sv
// Scoreboard bench for updown_seq_checker. The stimulus process drives one
// sample per cycle, advances a behavioural model and queues the expected
// outputs; a monitor pops one expectation after every clock edge.
// Build with +define+UPDN_CHK_ERRCNT_EN to also check o_err_cnt.
module tb_updown_seq_checker;

    localparam int W   = 3;
    localparam int LK  = 2;
    localparam int MAX = (1 << W) - 1;
    localparam int PER = 2 * MAX;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] cnt = '0;
    logic         locked, dir, err, pdone;
`ifdef UPDN_CHK_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    updown_seq_checker #(.WIDTH(W), .LOCK_CNT(LK)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cnt         (cnt),
        .o_locked      (locked),
        .o_dir         (dir),
        .o_err         (err),
        .o_period_done (pdone)
`ifdef UPDN_CHK_ERRCNT_EN
        ,
        .o_err_cnt     (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int dir;
        int err;
        int pd;
        int errcnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: mode 0 = waiting for first sample, 1 = hunting, 2 = tracking
    int m_mode, m_prev, m_dir, m_match, m_errcnt;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Value at phase position p of the triangle wave (0..PER-1).
    function automatic int tri_at(input int p);
        return (p <= MAX) ? p : PER - p;
    endfunction

    // Map (value, direction) to its phase and take one step along the wave.
    function automatic int tri_next(input int prev, input int d);
        int p;
        p = d ? prev : PER - prev;
        return tri_at((p + 1) % PER);
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_prev = 0; m_dir = 1; m_match = 0; m_errcnt = 0;
    endfunction

    function automatic exp_t model_step(input int v);
        exp_t e;
        int   nxt;
        e.err = 0;
        e.pd  = 0;
        nxt = tri_next(m_prev, m_dir);
        if (m_mode == 0) begin
            m_prev = v;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (v == nxt) begin
                m_match++;
                m_dir = (v > m_prev) ? 1 : 0;
            end else if (v == m_prev + 1 || v == m_prev - 1) begin
                m_match = 1;
                m_dir = (v > m_prev) ? 1 : 0;
            end else begin
                m_match = 0;
            end
            m_prev = v;
            if (m_match >= LK) m_mode = 2;
        end else begin
            if (v == nxt) begin
                m_dir  = (v > m_prev) ? 1 : 0;
                m_prev = v;
                e.pd   = (v == 0) ? 1 : 0;
            end else begin
                e.err   = 1;
                m_mode  = 1;
                m_match = 0;
                m_prev  = v;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        e.locked = (m_mode == 2) ? 1 : 0;
        e.dir    = m_dir;
        e.errcnt = m_errcnt;
        return e;
    endfunction

    task automatic drive(input int v);
        @(negedge clk);
        rst = 1'b0;
        cnt = W'(v);
        q.push_back(model_step(v));
    endtask

    task automatic drive_list(input int vals[$]);
        foreach (vals[i]) drive(vals[i]);
    endtask

    // Reset lands mid-cycle; outputs must clear before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_dir",    int'(dir),    1);
        chk("rst_err",    int'(err),    0);
        chk("rst_pdone",  int'(pdone),  0);
`ifdef UPDN_CHK_ERRCNT_EN
        chk("rst_errcnt", int'(err_cnt), 0);
`endif
        model_reset();
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q.size() > 0) begin
                e = q.pop_front();
                chk("locked", int'(locked), e.locked);
                chk("dir",    int'(dir),    e.dir);
                chk("err",    int'(err),    e.err);
                chk("pdone",  int'(pdone),  e.pd);
`ifdef UPDN_CHK_ERRCNT_EN
                chk("errcnt", int'(err_cnt), e.errcnt);
`endif
            end
        end
    end

    initial begin : stim
        int gpos;
        model_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("init_locked", int'(locked), 0);
        chk("init_dir",    int'(dir),    1);
        repeat (2) @(negedge clk);

        // Clean stream from 0 for several periods.
        for (int i = 0; i < 4 * PER + 3; i++) drive(tri_at(i % PER));

        // Miss while locked, then relock.
        do_reset();
        drive_list('{0, 1, 2, 3, 4, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2});

        // Acquire on the descending slope.
        do_reset();
        drive_list('{6, 5, 4, 3, 2, 1, 0, 1, 2});

        // Wrap 7->0, then a repeated 0 while locked at 0.
        do_reset();
        drive_list('{5, 6, 7, 0, 2, 1, 0, 0, 1, 2, 3});

        // Lock, async reset mid-cycle, identical lock sequence after release.
        do_reset();
        for (int i = 0; i < 20; i++) drive(tri_at(i % PER));
        do_reset();
        for (int i = 0; i < 20; i++) drive(tri_at(i % PER));

        // Random: a clean generator with occasional corrupted samples.
        gpos = $urandom_range(0, PER - 1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) drive($urandom_range(0, MAX));
            else drive(tri_at(gpos % PER));
            gpos++;
        end

        // Repeated forced misses: relock on 1,2,3 then break with 5.
        do_reset();
        for (int i = 0; i < 300; i++) drive_list('{1, 2, 3, 5});
        for (int i = 0; i < 4; i++) drive(tri_at(i % PER));

        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_seq_checker.md
# updown_seq_checker

Receive-side monitor for the 3-bit up/down repeating counter stream. Samples the count every clock, locks onto the triangle sequence 0,1,…,7,6,…,1,0,1,…, reports the current direction and each completed period, and flags any sample that breaks the sequence. It sits on the counter's output bus, in RTL and in benches, as the consumer and checker of that stream.

## Interface
- `WIDTH`, default 3: count width; the sequence maximum is MAX = 2^WIDTH−1.
- `LOCK_CNT`, default 2: number of consecutive valid steps needed to lock (1..7).
- `clk`, input, 1: single clock; rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `cnt`, input, WIDTH: observed count, sampled every rising edge.
- `locked`, output, 1: the sequence is being tracked.
- `dir`, output, 1: direction of the last accepted step; 1 = up, 0 = down.
- `err`, output, 1: one-cycle pulse when a locked prediction fails.
- `period_done`, output, 1: one-cycle pulse when a locked sample returns to 0.
- `err_cnt`, output, 8: saturating error count. Present only with `UPDN_CHK_ERRCNT_EN`.

## Operation
- Internal state: `prev` (last sample), `match` (3-bit count of consistent steps), and a state machine with states IDLE, ACQUIRE and LOCKED.
- **IDLE** (entered from reset): capture `cnt` into `prev`, then go to ACQUIRE. No flags are raised.
- **ACQUIRE**: each edge, classify the step `prev`→`cnt`:
  - `cnt == prev+1` is an up step; `cnt == prev−1` is a down step. No modular wrap: 7→0 and 0→7 are invalid.
  - A step is consistent if it matches `dir`, or if it is a legal turnaround: a down step from MAX, or an up step from 0.
  - Consistent step: `match++` and update `dir`.
  - Valid but inconsistent step: `match = 1` and update `dir`.
  - Invalid step (including equal values): `match = 0`.
  - When `match` reaches `LOCK_CNT`, go to LOCKED.
  - `prev` is updated every edge.
  - `err` is never asserted in ACQUIRE.
- **LOCKED**: compute the expected next value:
  - `prev == MAX`: expect MAX−1, next `dir` = 0.
  - `prev == 0`: expect 1, next `dir` = 1.
  - otherwise: expect `prev ± 1` according to `dir`.
  - On a hit: update `prev` and `dir`. Pulse `period_done` if `cnt == 0`.
  - On a miss: pulse `err`, clear `locked`, set `match = 0`, load `prev = cnt`, and go to ACQUIRE.
- The full period is 2·MAX samples (14 for WIDTH=3).
- Reset values: `locked`=0, `dir`=1, `err`=0, `period_done`=0, `err_cnt`=0, `prev`=0, `match`=0, state IDLE.
- A reset asserted mid-operation clears everything immediately (async). The first edge after release is the IDLE capture.

## Timing
- All outputs are registered. They reflect the sample taken at edge k and are valid right after edge k.
- `err` and `period_done` are high for exactly one cycle per event. Back-to-back events give back-to-back pulses.
- `locked` rises on the edge of the LOCK_CNT-th consistent step. From reset release on a clean stream, that is edge LOCK_CNT+1.
- After a miss, relocking needs at least LOCK_CNT further valid steps.
- A miss and a 0 sample on the same edge: `err`=1 and `period_done`=0.

## Configuration
- `UPDN_CHK_ERRCNT_EN` defined:
  - the `err_cnt` port exists;
  - it increments on every `err` pulse and saturates at 255;
  - it is cleared only by `rst`.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `updown_chk_pkg`:
  - state enum (IDLE, ACQUIRE, LOCKED);
  - default WIDTH and LOCK_CNT constants;
  - error-counter width (8).
- Sub-module `updown_predict`: combinational; takes `prev` and `dir`, produces the expected value and next `dir`, including the endpoint turnaround. The same logic serves as the consistency classifier in ACQUIRE.
- Top level holds the state machine, registers and optional counter.

## Test plan
- Clean stream from reset (0,1,2,…) → `locked`=1 after edge 3, `dir`=1. `dir`=0 after the 7→6 step. `period_done` pulses on each 0 sample, every 14 cycles. `err` never asserts over 2000 ns.
- Locked; drive 3 where 5 is expected → `err` pulses once and `locked`=0. Continue 4,5 (from `prev`=3) → relock. Continue 6 → `locked`=1 with no further `err`.
- Acquire mid-descent: reset, then 6,5,4 → `locked`=1, `dir`=0. Then 3,2,1,0 → `period_done` on the 0 sample, then `dir`=1 on the next sample, 1.
- Wrap violation: locked at 7, drive 0 → `err`. Drive 0 while locked at 0 → `err` (no `period_done`).
- Async reset asserted mid-cycle while locked → all outputs 0 (`dir`=1) before the next edge. After release, the lock sequence repeats exactly.
- With `UPDN_CHK_ERRCNT_EN`, 300 forced misses (alternate 0/5 after each relock, or a constant injector) → `err_cnt` saturates at 255 and holds. Without the macro, the bench compiles with no `err_cnt` port.
